// File: rtl/cfu_gateway_pkg.sv
// Shared types for the CFU gateway: configuration record, response status codes,
// request/response records and the request legality check.
package cfu_gateway_pkg;

   typedef struct packed {
      int unsigned req_id_w;
      int unsigned cfu_id_w;
      int unsigned state_id_w;
      int unsigned func_id_w;
      int unsigned insn_w;
      int unsigned data_w;
      int unsigned n_cfus;
      int unsigned n_states;
   } cfu_config_t;

   localparam cfu_config_t DEFAULT_CFU_CONFIG = '{
      req_id_w:   4,
      cfu_id_w:   2,
      state_id_w: 2,
      func_id_w:  10,
      insn_w:     32,
      data_w:     32,
      n_cfus:     1,
      n_states:   0
   };

   typedef enum logic [2:0] {
      CFU_OK          = 3'b000,
      CFU_ERROR_CFU   = 3'b001,
      CFU_ERROR_STATE = 3'b010,
      CFU_ERROR_INSN  = 3'b011
   } cfu_resp_status_t;

   localparam int unsigned STATUS_W = $bits(cfu_resp_status_t);

   typedef struct packed {
      logic [DEFAULT_CFU_CONFIG.req_id_w-1:0]   req_id;
      logic [DEFAULT_CFU_CONFIG.cfu_id_w-1:0]   cfu_id;
      logic [DEFAULT_CFU_CONFIG.state_id_w-1:0] state_id;
      logic [DEFAULT_CFU_CONFIG.func_id_w-1:0]  func_id;
      logic [DEFAULT_CFU_CONFIG.insn_w-1:0]     insn;
      logic [DEFAULT_CFU_CONFIG.data_w-1:0]     data0;
      logic [DEFAULT_CFU_CONFIG.data_w-1:0]     data1;
   } cfu_req_t;

   typedef struct packed {
      logic [DEFAULT_CFU_CONFIG.req_id_w-1:0] req_id;
      cfu_resp_status_t                       status;
      logic [DEFAULT_CFU_CONFIG.data_w-1:0]   data;
   } cfu_resp_t;

   // Priority: an unknown CFU is reported before a bad state context.
   function automatic cfu_resp_status_t cfu_check(input int unsigned cfu_id,
                                                  input int unsigned state_id,
                                                  input cfu_config_t cfg);
      cfu_resp_status_t res;
      res = CFU_OK;
      if (cfu_id >= cfg.n_cfus)
         res = CFU_ERROR_CFU;
      else if (cfg.n_states == 0 && state_id != 0)
         res = CFU_ERROR_STATE;
      else if (cfg.n_states > 0 && state_id >= cfg.n_states)
         res = CFU_ERROR_STATE;
      return res;
   endfunction

endpackage

// File: rtl/cfu_gateway_err_fifo.sv
// Small synchronous FIFO holding locally generated error responses until the
// response channel is free.
module cfu_gateway_err_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (32'(p) == DEPTH - 1)
         return '0;
      else
         return p + 1'b1;
   endfunction

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop)
         rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++)
            mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cfu_gateway.sv
// Gateway between the core CFU issue stage and the CFU-LI ports: forwards legal
// requests, answers illegal ones locally and merges both response sources.
module cfu_gateway
   import cfu_gateway_pkg::*;
#(
   parameter cfu_config_t CONFIG          = DEFAULT_CFU_CONFIG,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ERR_FIFO_DEPTH  = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  issue_valid,
   output logic                                  issue_ready,
   input  logic [CONFIG.req_id_w-1:0]            issue_req_id,
   input  logic [CONFIG.cfu_id_w-1:0]            issue_cfu_id,
   input  logic [CONFIG.state_id_w-1:0]          issue_state_id,
   input  logic [CONFIG.func_id_w-1:0]           issue_func_id,
   input  logic [CONFIG.insn_w-1:0]              issue_insn,
   input  logic [CONFIG.data_w-1:0]              issue_data0,
   input  logic [CONFIG.data_w-1:0]              issue_data1,
   output logic                                  cfu_req_valid,
   input  logic                                  cfu_req_ready,
   output logic [CONFIG.req_id_w-1:0]            cfu_req_req_id,
   output logic [CONFIG.cfu_id_w-1:0]            cfu_req_cfu_id,
   output logic [CONFIG.state_id_w-1:0]          cfu_req_state_id,
   output logic [CONFIG.func_id_w-1:0]           cfu_req_func_id,
   output logic [CONFIG.insn_w-1:0]              cfu_req_insn,
   output logic [CONFIG.data_w-1:0]              cfu_req_data0,
   output logic [CONFIG.data_w-1:0]              cfu_req_data1,
   input  logic                                  cfu_resp_valid,
   output logic                                  cfu_resp_ready,
   input  logic [CONFIG.req_id_w-1:0]            cfu_resp_id,
   input  logic [STATUS_W-1:0]                   cfu_resp_status,
   input  logic [CONFIG.data_w-1:0]              cfu_resp_data,
   output logic                                  core_resp_valid,
   input  logic                                  core_resp_ready,
   output logic [CONFIG.req_id_w-1:0]            core_resp_id,
   output logic [STATUS_W-1:0]                   core_resp_status,
   output logic [CONFIG.data_w-1:0]              core_resp_data,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
   output logic                                  protocol_error
);

   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned ERR_W = CONFIG.req_id_w + STATUS_W;

   cfu_resp_status_t     status;
   logic                 legal, room;
   logic                 req_fire, resp_fire, err_push, err_pop;
   logic                 err_full, err_empty;
   logic [ERR_W-1:0]     err_head;
   logic [OUT_W-1:0]     outstanding_q, outstanding_d;
   logic                 protocol_error_q, protocol_error_d;

   assign status = cfu_check(32'(issue_cfu_id), 32'(issue_state_id), CONFIG);
   assign legal  = (status == CFU_OK);
   assign room   = (outstanding_q < OUT_W'(MAX_OUTSTANDING));

   assign cfu_req_valid    = issue_valid && legal && room;
   assign issue_ready      = legal ? (cfu_req_ready && room) : !err_full;
   assign cfu_req_req_id   = issue_req_id;
   assign cfu_req_cfu_id   = issue_cfu_id;
   assign cfu_req_state_id = issue_state_id;
   assign cfu_req_func_id  = issue_func_id;
   assign cfu_req_insn     = issue_insn;
   assign cfu_req_data0    = issue_data0;
   assign cfu_req_data1    = issue_data1;

   assign req_fire  = cfu_req_valid && cfu_req_ready;
   assign err_push  = issue_valid && !legal && !err_full;

   // CFU responses always win; the error FIFO only drains in idle CFU cycles.
   assign cfu_resp_ready   = core_resp_ready;
   assign resp_fire        = cfu_resp_valid && core_resp_ready;
   assign err_pop          = !cfu_resp_valid && !err_empty && core_resp_ready;
   assign core_resp_valid  = cfu_resp_valid || !err_empty;
   assign core_resp_id     = cfu_resp_valid ? cfu_resp_id : err_head[ERR_W-1:STATUS_W];
   assign core_resp_status = cfu_resp_valid ? cfu_resp_status : err_head[STATUS_W-1:0];
   assign core_resp_data   = cfu_resp_valid ? cfu_resp_data : '0;

   cfu_gateway_err_fifo #(
      .WIDTH (ERR_W),
      .DEPTH (ERR_FIFO_DEPTH)
   ) u_err_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (err_push),
      .push_data ({issue_req_id, status}),
      .pop       (err_pop),
      .pop_data  (err_head),
      .full      (err_full),
      .empty     (err_empty)
   );

   always_comb begin
      outstanding_d    = outstanding_q;
      protocol_error_d = protocol_error_q;
      if (resp_fire && outstanding_q == '0)
         protocol_error_d = 1'b1;
      case ({req_fire, resp_fire})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q    <= '0;
         protocol_error_q <= 1'b0;
      end else begin
         outstanding_q    <= outstanding_d;
         protocol_error_q <= protocol_error_d;
      end
   end

   assign outstanding    = outstanding_q;
   assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_cfu_gateway.sv
// Bench for cfu_gateway with the default configuration (one CFU, no state contexts,
// four outstanding requests, two-entry error FIFO).
module tb_cfu_gateway;
   import cfu_gateway_pkg::*;

   localparam int RID_W = 4;
   localparam int DW    = 32;
   localparam int MAXO  = 4;
   localparam int EDEP  = 2;
   localparam int EW    = RID_W + 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue_valid, issue_ready;
   logic [RID_W-1:0]  issue_req_id;
   logic [1:0]        issue_cfu_id, issue_state_id;
   logic [9:0]        issue_func_id;
   logic [31:0]       issue_insn;
   logic [DW-1:0]     issue_data0, issue_data1;
   logic              cfu_req_valid, cfu_req_ready;
   logic [RID_W-1:0]  cfu_req_req_id;
   logic [1:0]        cfu_req_cfu_id, cfu_req_state_id;
   logic [9:0]        cfu_req_func_id;
   logic [31:0]       cfu_req_insn;
   logic [DW-1:0]     cfu_req_data0, cfu_req_data1;
   logic              cfu_resp_valid, cfu_resp_ready;
   logic [RID_W-1:0]  cfu_resp_id;
   logic [2:0]        cfu_resp_status;
   logic [DW-1:0]     cfu_resp_data;
   logic              core_resp_valid, core_resp_ready;
   logic [RID_W-1:0]  core_resp_id;
   logic [2:0]        core_resp_status;
   logic [DW-1:0]     core_resp_data;
   logic [2:0]        outstanding;
   logic              protocol_error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cfu_gateway dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_req_id(issue_req_id), .issue_cfu_id(issue_cfu_id),
      .issue_state_id(issue_state_id), .issue_func_id(issue_func_id),
      .issue_insn(issue_insn), .issue_data0(issue_data0), .issue_data1(issue_data1),
      .cfu_req_valid(cfu_req_valid), .cfu_req_ready(cfu_req_ready),
      .cfu_req_req_id(cfu_req_req_id), .cfu_req_cfu_id(cfu_req_cfu_id),
      .cfu_req_state_id(cfu_req_state_id), .cfu_req_func_id(cfu_req_func_id),
      .cfu_req_insn(cfu_req_insn), .cfu_req_data0(cfu_req_data0), .cfu_req_data1(cfu_req_data1),
      .cfu_resp_valid(cfu_resp_valid), .cfu_resp_ready(cfu_resp_ready),
      .cfu_resp_id(cfu_resp_id), .cfu_resp_status(cfu_resp_status), .cfu_resp_data(cfu_resp_data),
      .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
      .core_resp_id(core_resp_id), .core_resp_status(core_resp_status), .core_resp_data(core_resp_data),
      .outstanding(outstanding), .protocol_error(protocol_error)
   );

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      issue_valid = 1'b0; issue_req_id = '0; issue_cfu_id = '0; issue_state_id = '0;
      issue_func_id = '0; issue_insn = '0; issue_data0 = '0; issue_data1 = '0;
      cfu_req_ready = 1'b0; cfu_resp_valid = 1'b0; cfu_resp_id = '0;
      cfu_resp_status = '0; cfu_resp_data = '0; core_resp_ready = 1'b0;
   endtask

   task automatic drive_issue(input logic [RID_W-1:0] id, input logic [1:0] cfu,
                              input logic [1:0] st, input logic [DW-1:0] d0);
      issue_valid = 1'b1; issue_req_id = id; issue_cfu_id = cfu;
      issue_state_id = st; issue_data0 = d0;
   endtask

   task automatic drive_cfu_resp(input logic [RID_W-1:0] id, input logic [2:0] st,
                                 input logic [DW-1:0] d);
      cfu_resp_valid = 1'b1; cfu_resp_id = id; cfu_resp_status = st; cfu_resp_data = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
      n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL reset_protocol_error: got %0b expected 0", protocol_error); end
      n_checks++; if (core_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_core_resp_valid: got %0b expected 0", core_resp_valid); end
      n_checks++; if (cfu_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cfu_req_valid: got %0b expected 0", cfu_req_valid); end
      rst = 1'b0;
   endtask

   task automatic test_legal();
      @(negedge clk);
      drive_issue(4'd1, 2'd0, 2'd0, 32'd5);
      cfu_req_ready = 1'b1;
      #1;
      n_checks++; if (cfu_req_valid !== 1'b1) begin n_fail++; $display("FAIL legal_req_valid: got %0b expected 1", cfu_req_valid); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL legal_issue_ready: got %0b expected 1", issue_ready); end
      n_checks++; if (cfu_req_data0 !== 32'd5) begin n_fail++; $display("FAIL legal_data0: got %0h expected 5", cfu_req_data0); end
      n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL legal_out_before: got %0d expected 0", outstanding); end
      @(negedge clk);
      issue_valid = 1'b0;
      #1;
      n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL legal_out_after: got %0d expected 1", outstanding); end
      drive_cfu_resp(4'd3, 3'b000, 32'h2A);
      core_resp_ready = 1'b1;
      #1;
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== 4'd3 || core_resp_status !== 3'b000 || core_resp_data !== 32'h2A)
         begin n_fail++; $display("FAIL legal_resp: got v=%0b id=%0d st=%0b d=%0h expected v=1 id=3 st=0 d=2a", core_resp_valid, core_resp_id, core_resp_status, core_resp_data); end
      n_checks++; if (cfu_resp_ready !== 1'b1) begin n_fail++; $display("FAIL legal_resp_ready: got %0b expected 1", cfu_resp_ready); end
      @(negedge clk);
      cfu_resp_valid = 1'b0;
      #1;
      n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL legal_out_drained: got %0d expected 0", outstanding); end
   endtask

   task automatic test_illegal();
      @(negedge clk);
      drive_issue(4'd7, 2'd1, 2'd0, 32'h99);
      core_resp_ready = 1'b1;
      #1;
      n_checks++; if (cfu_req_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_req_valid: got %0b expected 0", cfu_req_valid); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_issue_ready: got %0b expected 1", issue_ready); end
      n_checks++; if (core_resp_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_same_cycle: got %0b expected 0", core_resp_valid); end
      @(negedge clk);
      issue_valid = 1'b0;
      #1;
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== 4'd7 || core_resp_status !== 3'b001 || core_resp_data !== 32'd0)
         begin n_fail++; $display("FAIL illegal_cfu_resp: got v=%0b id=%0d st=%0b d=%0h expected v=1 id=7 st=1 d=0", core_resp_valid, core_resp_id, core_resp_status, core_resp_data); end
      n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL illegal_outstanding: got %0d expected 0", outstanding); end
      @(negedge clk);
      drive_issue(4'd9, 2'd0, 2'd2, 32'h0);
      @(negedge clk);
      issue_valid = 1'b0;
      #1;
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== 4'd9 || core_resp_status !== 3'b010)
         begin n_fail++; $display("FAIL illegal_state_resp: got v=%0b id=%0d st=%0b expected v=1 id=9 st=2", core_resp_valid, core_resp_id, core_resp_status); end
      @(negedge clk);
      #1;
      n_checks++; if (core_resp_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_drained: got %0b expected 0", core_resp_valid); end
   endtask

   task automatic test_back_to_back();
      cfu_req_ready = 1'b1;
      core_resp_ready = 1'b1;
      for (int i = 0; i < MAXO; i++) begin
         @(negedge clk);
         drive_issue(RID_W'(i), 2'd0, 2'd0, DW'(i));
         #1;
         n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_%0d: got %0b expected 1", i, issue_ready); end
      end
      @(negedge clk);
      drive_issue(4'd4, 2'd0, 2'd0, 32'h4);
      #1;
      n_checks++; if (issue_ready !== 1'b0 || cfu_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got ready=%0b valid=%0b expected 0 0", issue_ready, cfu_req_valid); end
      n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL b2b_full_count: got %0d expected 4", outstanding); end
      drive_issue(4'd5, 2'd1, 2'd0, 32'h0);
      #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_illegal_at_max: got %0b expected 1", issue_ready); end
      @(negedge clk);
      drive_issue(4'd4, 2'd0, 2'd0, 32'h4);
      drive_cfu_resp(4'd0, 3'b000, 32'h10);
      #1;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_still_stalled: got %0b expected 0", issue_ready); end
      n_checks++; if (core_resp_id !== 4'd0 || core_resp_data !== 32'h10) begin n_fail++; $display("FAIL b2b_cfu_priority: got id=%0d d=%0h expected id=0 d=10", core_resp_id, core_resp_data); end
      @(negedge clk);
      cfu_resp_valid = 1'b0;
      #1;
      n_checks++; if (issue_ready !== 1'b1 || outstanding !== 3'd3) begin n_fail++; $display("FAIL b2b_fifth_accept: got ready=%0b out=%0d expected 1 3", issue_ready, outstanding); end
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== 4'd5 || core_resp_status !== 3'b001)
         begin n_fail++; $display("FAIL b2b_err_after: got v=%0b id=%0d st=%0b expected 1 5 1", core_resp_valid, core_resp_id, core_resp_status); end
      @(negedge clk);
      issue_valid = 1'b0;
      #1;
      n_checks++; if (outstanding !== 3'd4 || core_resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after_fifth: got out=%0d v=%0b expected 4 0", outstanding, core_resp_valid); end
      for (int i = 0; i < MAXO; i++) begin
         drive_cfu_resp(RID_W'(i + 1), 3'b000, 32'h0);
         @(negedge clk);
      end
      cfu_resp_valid = 1'b0;
      #1;
      n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 0", outstanding); end
   endtask

   task automatic test_merge();
      core_resp_ready = 1'b0;
      cfu_req_ready = 1'b1;
      @(negedge clk);
      drive_issue(4'd2, 2'd0, 2'd0, 32'h1);
      @(negedge clk);
      drive_issue(4'd6, 2'd1, 2'd0, 32'h0);
      @(negedge clk);
      issue_valid = 1'b0;
      drive_cfu_resp(4'd2, 3'b000, 32'h55);
      #1;
      n_checks++; if (core_resp_id !== 4'd2 || core_resp_data !== 32'h55 || cfu_resp_ready !== 1'b0)
         begin n_fail++; $display("FAIL merge_cfu_first: got id=%0d d=%0h rr=%0b expected 2 55 0", core_resp_id, core_resp_data, cfu_resp_ready); end
      @(negedge clk);
      #1;
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== 4'd2 || core_resp_data !== 32'h55)
         begin n_fail++; $display("FAIL merge_cfu_held: got v=%0b id=%0d d=%0h expected 1 2 55", core_resp_valid, core_resp_id, core_resp_data); end
      core_resp_ready = 1'b1;
      @(negedge clk);
      cfu_resp_valid = 1'b0;
      core_resp_ready = 1'b0;
      #1;
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== 4'd6 || core_resp_status !== 3'b001)
         begin n_fail++; $display("FAIL merge_err_second: got v=%0b id=%0d st=%0b expected 1 6 1", core_resp_valid, core_resp_id, core_resp_status); end
      @(negedge clk);
      #1;
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== 4'd6) begin n_fail++; $display("FAIL merge_err_held: got v=%0b id=%0d expected 1 6", core_resp_valid, core_resp_id); end
      core_resp_ready = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (core_resp_valid !== 1'b0 || outstanding !== 3'd0) begin n_fail++; $display("FAIL merge_idle: got v=%0b out=%0d expected 0 0", core_resp_valid, outstanding); end
   endtask

   task automatic test_fifo_full();
      core_resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_issue(RID_W'(10 + i), 2'd1, 2'd0, 32'h0);
         #1;
         n_checks++; if (issue_ready !== (i < EDEP)) begin n_fail++; $display("FAIL fifo_ready_%0d: got %0b expected %0b", i, issue_ready, (i < EDEP)); end
      end
      @(negedge clk);
      issue_valid = 1'b0;
      core_resp_ready = 1'b1;
      for (int i = 0; i < EDEP; i++) begin
         #1;
         n_checks++; if (core_resp_valid !== 1'b1 || core_resp_id !== RID_W'(10 + i))
            begin n_fail++; $display("FAIL fifo_drain_%0d: got v=%0b id=%0d expected 1 %0d", i, core_resp_valid, core_resp_id, 10 + i); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (core_resp_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty: got %0b expected 0", core_resp_valid); end
   endtask

   task automatic test_random();
      int               m_out;
      logic [EW-1:0]    exp_q[$];
      logic [2:0]       e_st;
      logic             e_room, e_rdy, e_rv, e_cv;
      logic [RID_W-1:0] e_id;
      logic [2:0]       e_cst;
      logic [DW-1:0]    e_d;
      m_out = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         issue_valid     = 1'($urandom_range(0, 1));
         issue_req_id    = RID_W'($urandom_range(0, 15));
         issue_cfu_id    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         issue_state_id  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         issue_func_id   = 10'($urandom_range(0, 1023));
         issue_insn      = $urandom;
         issue_data0     = $urandom;
         issue_data1     = $urandom;
         cfu_req_ready   = 1'($urandom_range(0, 1));
         core_resp_ready = ($urandom_range(0, 3) != 0);
         cfu_resp_valid  = (m_out > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         cfu_resp_id     = RID_W'($urandom_range(0, 15));
         cfu_resp_status = 3'($urandom_range(0, 1));
         cfu_resp_data   = $urandom;
         #1;
         e_st   = (issue_cfu_id >= 2'd1) ? 3'b001 : ((issue_state_id != 2'd0) ? 3'b010 : 3'b000);
         e_room = (m_out < MAXO);
         e_rdy  = (e_st == 3'b000) ? (cfu_req_ready && e_room) : (exp_q.size() < EDEP);
         e_rv   = issue_valid && (e_st == 3'b000) && e_room;
         e_cv   = cfu_resp_valid || (exp_q.size() > 0);
         if (cfu_resp_valid) begin
            e_id = cfu_resp_id; e_cst = cfu_resp_status; e_d = cfu_resp_data;
         end else if (exp_q.size() > 0) begin
            {e_id, e_cst} = exp_q[0]; e_d = '0;
         end else begin
            e_id = '0; e_cst = '0; e_d = '0;
         end
         n_checks++; if (issue_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_issue_ready c%0d: got %0b expected %0b", cyc, issue_ready, e_rdy); end
         n_checks++; if (cfu_req_valid !== e_rv) begin n_fail++; $display("FAIL rnd_cfu_req_valid c%0d: got %0b expected %0b", cyc, cfu_req_valid, e_rv); end
         n_checks++; if (cfu_req_insn !== issue_insn || cfu_req_data1 !== issue_data1 || cfu_req_func_id !== issue_func_id)
            begin n_fail++; $display("FAIL rnd_passthrough c%0d: got %0h/%0h expected %0h/%0h", cyc, cfu_req_insn, cfu_req_data1, issue_insn, issue_data1); end
         n_checks++; if (outstanding !== 3'(m_out)) begin n_fail++; $display("FAIL rnd_outstanding c%0d: got %0d expected %0d", cyc, outstanding, m_out); end
         n_checks++; if (core_resp_valid !== e_cv) begin n_fail++; $display("FAIL rnd_core_valid c%0d: got %0b expected %0b", cyc, core_resp_valid, e_cv); end
         if (e_cv) begin
            n_checks++; if (core_resp_id !== e_id || core_resp_status !== e_cst || core_resp_data !== e_d)
               begin n_fail++; $display("FAIL rnd_core_fields c%0d: got %0d/%0b/%0h expected %0d/%0b/%0h", cyc, core_resp_id, core_resp_status, core_resp_data, e_id, e_cst, e_d); end
         end
         if (e_rv && cfu_req_ready) m_out++;
         if (cfu_resp_valid && core_resp_ready) m_out--;
         if (!cfu_resp_valid && exp_q.size() > 0 && core_resp_ready) void'(exp_q.pop_front());
         if (issue_valid && e_st != 3'b000 && e_rdy) exp_q.push_back({issue_req_id, e_st});
      end
      n_checks++; if (protocol_error !== 1'b0) begin n_fail++; $display("FAIL rnd_no_protocol_error: got %0b expected 0", protocol_error); end
      do_reset();
   endtask

   task automatic test_protocol_and_reset();
      @(negedge clk);
      drive_idle();
      core_resp_ready = 1'b1;
      drive_cfu_resp(4'd1, 3'b000, 32'h77);
      #1;
      n_checks++; if (core_resp_valid !== 1'b1 || core_resp_data !== 32'h77) begin n_fail++; $display("FAIL spurious_forwarded: got v=%0b d=%0h expected 1 77", core_resp_valid, core_resp_data); end
      @(negedge clk);
      cfu_resp_valid = 1'b0;
      #1;
      n_checks++; if (protocol_error !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL spurious_flag: got pe=%0b out=%0d expected 1 0", protocol_error, outstanding); end
      cfu_req_ready = 1'b1;
      drive_issue(4'd2, 2'd0, 2'd0, 32'h1);
      @(negedge clk);
      drive_issue(4'd3, 2'd0, 2'd0, 32'h2);
      core_resp_ready = 1'b0;
      @(negedge clk);
      drive_issue(4'd8, 2'd1, 2'd0, 32'h0);
      @(negedge clk);
      issue_valid = 1'b0;
      #1;
      n_checks++; if (protocol_error !== 1'b1 || outstanding !== 3'd2 || core_resp_valid !== 1'b1)
         begin n_fail++; $display("FAIL pre_reset_state: got pe=%0b out=%0d v=%0b expected 1 2 1", protocol_error, outstanding, core_resp_valid); end
      #1;
      rst = 1'b1;
      #1;
      n_checks++; if (outstanding !== 3'd0 || protocol_error !== 1'b0 || core_resp_valid !== 1'b0)
         begin n_fail++; $display("FAIL async_reset: got out=%0d pe=%0b v=%0b expected 0 0 0", outstanding, protocol_error, core_resp_valid); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (outstanding !== 3'd0 || protocol_error !== 1'b0 || core_resp_valid !== 1'b0)
         begin n_fail++; $display("FAIL post_reset: got out=%0d pe=%0b v=%0b expected 0 0 0", outstanding, protocol_error, core_resp_valid); end
   endtask

   initial begin
      test_reset();
      test_legal();
      test_illegal();
      test_back_to_back();
      test_merge();
      test_fifo_full();
      test_random();
      test_protocol_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
